// File: rtl/parameterized_decade_down_counter_pkg.sv
// Shared BCD definitions for the decade counters in the timer/sequencer datapath.
// Holds the digit width, the digit limits, the digit type and a clamp helper.
package parameterized_decade_down_counter_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/parameterized_decade_down_counter_bcd_down_digit.sv
// One registered BCD digit of the down-counter.
// The digit decrements on borrow_in and passes the borrow on while it sits at zero.
module bcd_down_digit
    import parameterized_decade_down_counter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       borrow_in,
    input  logic       hold,
    input  logic       load,
    input  bcd_digit_t load_digit,
    output bcd_digit_t digit,
    output bcd_digit_t digit_next,
    output logic       borrow_out
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;

    // A load wins over a borrow; hold freezes the whole counter at zero when it saturates.
    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = bcd_clamp(load_digit);
        end else if (borrow_in && !hold) begin
            digit_d = (digit_q == BCD_ZERO) ? BCD_MAX : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= BCD_ZERO;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit      = digit_q;
    assign digit_next = digit_d;
    assign borrow_out = borrow_in & (digit_q == BCD_ZERO);

endmodule

// File: rtl/parameterized_decade_down_counter.sv
// Cascadable BCD down-counter with parallel load, wrap or saturate at zero,
// a combinational terminal count for chaining, and registered zero/load_err flags.
module parameterized_decade_down_counter
    import parameterized_decade_down_counter_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  zero,
    output logic                  load_err
);

    localparam int CW = BCD_W * DIGITS;

    logic [DIGITS:0] borrow;
    logic [CW-1:0]   count_next;
    logic            sat_hold;
    logic            zero_d;
    logic            zero_q;
    logic            load_err_d;
    logic            load_err_q;

    // The chain is seeded with raw enable, so its far end is exactly enable & (count == 0).
    assign borrow[0] = enable;
    assign sat_hold  = !WRAP && (count == '0);

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            bcd_down_digit u_digit (
                .clk        (clk),
                .rst_n      (rst_n),
                .borrow_in  (borrow[i]),
                .hold       (sat_hold),
                .load       (load),
                .load_digit (load_value[BCD_W*i +: BCD_W]),
                .digit      (count[BCD_W*i +: BCD_W]),
                .digit_next (count_next[BCD_W*i +: BCD_W]),
                .borrow_out (borrow[i+1])
            );
        end
    endgenerate

    assign tc = borrow[DIGITS];

    always_comb begin
        zero_d     = (count_next == '0);
        load_err_d = 1'b0;
        if (load) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (load_value[BCD_W*i +: BCD_W] > BCD_MAX) begin
                    load_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q     <= 1'b1;
            load_err_q <= 1'b0;
        end else begin
            zero_q     <= zero_d;
            load_err_q <= load_err_d;
        end
    end

    assign zero     = zero_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_parameterized_decade_down_counter.sv
// Directed scoreboard bench for two 2-digit down-counters sharing stimulus,
// one wrapping and one saturating, checked against a decimal reference model.
module tb_parameterized_decade_down_counter;

    typedef struct {
        logic [7:0] count;
        logic       zero;
        logic       err;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       load;
    logic [7:0] load_value;
    logic [7:0] count_w, count_s;
    logic       tc_w, tc_s, zero_w, zero_s, err_w, err_s;

    int   checks;
    int   errors;
    int   m_val [2];
    exp_t q_w [$];
    exp_t q_s [$];

    parameterized_decade_down_counter #(.DIGITS(2), .WRAP(1'b1)) u_dut_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .count      (count_w),
        .tc         (tc_w),
        .zero       (zero_w),
        .load_err   (err_w)
    );

    parameterized_decade_down_counter #(.DIGITS(2), .WRAP(1'b0)) u_dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .count      (count_s),
        .tc         (tc_s),
        .zero       (zero_s),
        .load_err   (err_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[3:0] = 4'(v % 10);
        r[7:4] = 4'(v / 10);
        return r;
    endfunction

    function automatic int clamp_val(input logic [7:0] lv);
        int d0;
        int d1;
        d0 = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
        d1 = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
        return d1 * 10 + d0;
    endfunction

    task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkValue({tag, " count_w"}, count_w, 8'h00);
        checkValue({tag, " count_s"}, count_s, 8'h00);
        checkValue({tag, " zero_w"}, {7'd0, zero_w}, 8'd1);
        checkValue({tag, " zero_s"}, {7'd0, zero_s}, 8'd1);
        checkValue({tag, " err_w"}, {7'd0, err_w}, 8'd0);
        checkValue({tag, " err_s"}, {7'd0, err_s}, 8'd0);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (q_w.size() == 0 || q_s.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s scoreboard empty observed %0d expected 1", tag, q_w.size());
            return;
        end
        e = q_w.pop_front();
        checkValue({tag, " count_w"}, count_w, e.count);
        checkValue({tag, " zero_w"}, {7'd0, zero_w}, {7'd0, e.zero});
        checkValue({tag, " err_w"}, {7'd0, err_w}, {7'd0, e.err});
        e = q_s.pop_front();
        checkValue({tag, " count_s"}, count_s, e.count);
        checkValue({tag, " zero_s"}, {7'd0, zero_s}, {7'd0, e.zero});
        checkValue({tag, " err_s"}, {7'd0, err_s}, {7'd0, e.err});
    endtask

    task automatic applyStimulus(input string tag, input logic en, input logic ld, input logic [7:0] lv);
        exp_t e;
        enable     = en;
        load       = ld;
        load_value = lv;
        #1;
        checkValue({tag, " tc_w"}, {7'd0, tc_w}, {7'd0, (en && m_val[0] == 0)});
        checkValue({tag, " tc_s"}, {7'd0, tc_s}, {7'd0, (en && m_val[1] == 0)});
        for (int k = 0; k < 2; k++) begin
            e.err = 1'b0;
            if (ld) begin
                m_val[k] = clamp_val(lv);
                e.err    = (lv[3:0] > 4'd9) || (lv[7:4] > 4'd9);
            end else if (en) begin
                if (m_val[k] == 0) m_val[k] = (k == 0) ? 99 : 0;
                else               m_val[k] = m_val[k] - 1;
            end
            e.count = to_bcd(m_val[k]);
            e.zero  = (m_val[k] == 0);
            if (k == 0) q_w.push_back(e);
            else        q_s.push_back(e);
        end
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        m_val[0]   = 0;
        m_val[1]   = 0;
        rst_n      = 1'b0;
        enable     = 1'b0;
        load       = 1'b0;
        load_value = 8'h00;

        #12;
        checkReset("reset");
        checkValue("reset tc_w", {7'd0, tc_w}, 8'd0);
        checkValue("reset tc_s", {7'd0, tc_s}, 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) applyStimulus("idle", 1'b0, 1'b0, 8'h00);

        applyStimulus("load12", 1'b0, 1'b1, 8'h12);
        applyStimulus("dec11", 1'b1, 1'b0, 8'h00);
        applyStimulus("dec10", 1'b1, 1'b0, 8'h00);
        applyStimulus("dec09", 1'b1, 1'b0, 8'h00);

        applyStimulus("load01", 1'b0, 1'b1, 8'h01);
        applyStimulus("dec00", 1'b1, 1'b0, 8'h00);
        applyStimulus("wrap", 1'b1, 1'b0, 8'h00);
        applyStimulus("after_wrap", 1'b1, 1'b0, 8'h00);
        applyStimulus("hold", 1'b0, 1'b0, 8'h00);

        applyStimulus("load02", 1'b0, 1'b1, 8'h02);
        for (int i = 0; i < 4; i++) applyStimulus("sat", 1'b1, 1'b0, 8'h00);

        applyStimulus("loadA3", 1'b0, 1'b1, 8'hA3);
        applyStimulus("err_clear", 1'b0, 1'b0, 8'h00);
        applyStimulus("loadFF", 1'b1, 1'b1, 8'hFF);
        applyStimulus("dec98", 1'b1, 1'b0, 8'h00);

        applyStimulus("load00", 1'b1, 1'b1, 8'h00);
        applyStimulus("load45_en", 1'b1, 1'b1, 8'h45);
        applyStimulus("dec44", 1'b1, 1'b0, 8'h00);

        // Pull reset between clock edges while still counting.
        enable = 1'b1;
        load   = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checkReset("async_rst");
        m_val[0] = 0;
        m_val[1] = 0;
        enable   = 1'b0;
        @(posedge clk);
        #1;
        checkReset("rst_held");
        rst_n = 1'b1;
        applyStimulus("post_rst_load", 1'b0, 1'b1, 8'h30);
        applyStimulus("post_rst_dec", 1'b1, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
